fpaddsub_norm_pipe: RTL

Parametrised, pipelined normalisation stage for the FP add/sub datapath. It takes the unnormalised post-add sum and common exponent, computes the leading-zero count internally instead of taking a precomputed shift, and normalises the sum with a full-range left shift. It produces the normalised mantissa, adjusted exponent, zero and negative-exponent flags, and guard/round/sticky bits. It sits between the add stage and the rounding stage, with valid/ready handshakes on both sides.

---
 rtl/fpaddsub_pkg.sv | 11 +
 rtl/fpaddsub_lzc.sv | 32 +++
 rtl/fpaddsub_norm_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/fpaddsub_pkg.sv
// Shared constants for the FP add/sub datapath: default field widths and the
// widths derived from them for the normalisation stage.
package fpaddsub_pkg;

    localparam int DEF_EXP_W    = 8;
    localparam int DEF_MAN_W    = 23;
    localparam int DEF_SUM_W    = DEF_MAN_W + 10;
    localparam int DEF_STICKY_W = DEF_SUM_W - DEF_MAN_W - 3;
    localparam int DEF_LZ_W     = $clog2(DEF_SUM_W + 1);

endpackage

// File: rtl/fpaddsub_lzc.sv
// Combinational leading-zero counter. Resolves one count bit per level,
// from the MSB of the count down, so depth grows with log2 of the width.
module fpaddsub_lzc #(
    parameter int WIDTH = 33,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    localparam int PAD_W = 1 << CNT_W;

    // Ones padded below the value stop the search at exactly WIDTH for a zero input.
    logic [PAD_W-1:0] padded;
    logic [PAD_W-1:0] cur;

    assign padded = {value, {(PAD_W - WIDTH){1'b1}}};

    // NOTE: combinational blocks use blocking '=' so each level sees the previous one;
    // every variable gets a default first so no latch is inferred.
    always_comb begin
        cur   = padded;
        count = '0;
        for (int k = CNT_W - 1; k >= 0; k--) begin
            if ((cur >> (PAD_W - (1 << k))) == '0) begin
                count[k] = 1'b1;
                cur      = cur << (1 << k);
            end
        end
    end

endmodule

// File: rtl/fpaddsub_norm_pipe.sv
// Two-stage normalisation pipeline between the FP add and rounding stages:
// S1 captures the sum and its leading-zero count, S2 shifts and forms the fields.
module fpaddsub_norm_pipe
    import fpaddsub_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int SUM_W = MAN_W + 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic [EXP_W-1:0] in_cexp,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] out_norm_m,
    output logic [EXP_W:0]   out_norm_e,
    output logic             out_zero,
    output logic             out_neg_e,
    output logic             out_fg,
    output logic             out_r,
    output logic             out_s,
    output logic             out_sign
);

    localparam int LZ_W = $clog2(SUM_W + 1);
    localparam logic [EXP_W:0] E_ONE = (EXP_W + 1)'(1);

    logic             s1_v;
    logic [SUM_W-1:0] s1_sum;
    logic [EXP_W-1:0] s1_cexp;
    logic             s1_sign;
    logic [LZ_W-1:0]  s1_lz;
    logic             s1_zero;
    logic             s2_v;

    logic             s1_load;
    logic             s2_load;
    logic [LZ_W-1:0]  lz;
    logic [SUM_W-1:0] sh;
    logic [EXP_W:0]   e_calc;

    assign s2_load  = !s2_v || out_ready;
    assign s1_load  = !s1_v || s2_load;
    assign in_ready = s1_load;

    fpaddsub_lzc #(
        .WIDTH (SUM_W),
        .CNT_W (LZ_W)
    ) u_lzc (
        .value (in_sum),
        .count (lz)
    );

    // NOTE: sequential state always uses non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_sum  <= '0;
            s1_cexp <= '0;
            s1_sign <= 1'b0;
            s1_lz   <= '0;
            s1_zero <= 1'b0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_sum  <= in_sum;
                s1_cexp <= in_cexp;
                s1_sign <= in_sign;
                s1_lz   <= lz;
                s1_zero <= (in_sum == '0);
            end
        end
    end

    // Barrel shifter: one conditional power-of-two shift per lz bit.
    always_comb begin
        sh = s1_sum;
        for (int k = 0; k < LZ_W; k++) begin
            if (s1_lz[k]) begin
                sh = sh << (1 << k);
            end
        end
    end

    assign e_calc = {1'b0, s1_cexp} + E_ONE - (EXP_W + 1)'(s1_lz);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v       <= 1'b0;
            out_norm_m <= '0;
            out_norm_e <= '0;
            out_zero   <= 1'b0;
            out_fg     <= 1'b0;
            out_r      <= 1'b0;
            out_s      <= 1'b0;
            out_sign   <= 1'b0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_norm_m <= sh[SUM_W-2 -: MAN_W];
                out_norm_e <= s1_zero ? '0 : e_calc;
                out_zero   <= s1_zero;
                out_fg     <= sh[SUM_W-2-MAN_W];
                out_r      <= sh[SUM_W-3-MAN_W];
                out_s      <= |sh[SUM_W-4-MAN_W:0];
                out_sign   <= s1_sign;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_neg_e = out_norm_e[EXP_W];

endmodule
